// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use bubble insertion, branch flush, memory-wait freeze
// with timeout error, and saturating stall statistics.
module pipeline_hazard_controller #(
  parameter int REG_W      = 5,
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [REG_W-1:0] i_ID_rs,
  input  logic [REG_W-1:0] i_ID_rt,
  input  logic             i_ID_UsesRt,
  input  logic             i_EX_MemRead,
  input  logic [REG_W-1:0] i_EX_WriteRegister,
  input  logic             i_EX_BranchTaken,
  input  logic             i_MEM_MemAccess,
  input  logic             i_MemReady,
  output logic             o_PC_Write,
  output logic             o_IFID_Write,
  output logic             o_IFID_Flush,
  output logic             o_IDEX_Bubble,
  output logic             o_Freeze,
  output logic             o_MemError,
  output logic [CNT_W-1:0] o_StallCount
);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [WCNT_W-1:0] LIMIT_VAL = WCNT_W'(WAIT_LIMIT);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_MEMWAIT = 2'd1;
  localparam logic [1:0] S_ERROR   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic [WCNT_W-1:0] r_waitCnt;
  logic [WCNT_W-1:0] w_nextWaitCnt;
  logic              r_memError;
  logic [CNT_W-1:0]  r_stallCount;

  logic w_memWait;
  logic w_loadUse;
  logic w_pcWrite;
  logic w_ifidWrite;
  logic w_ifidFlush;
  logic w_idexBubble;
  logic w_freeze;
  logic w_stallCycle;

  assign w_memWait = i_MEM_MemAccess & ~i_MemReady;
  // A write to register 0 never creates a real dependence.
  assign w_loadUse = i_EX_MemRead & (i_EX_WriteRegister != '0) &
                     ((i_EX_WriteRegister == i_ID_rs) |
                      (i_ID_UsesRt & (i_EX_WriteRegister == i_ID_rt)));

  always_comb begin
    w_pcWrite     = 1'b1;
    w_ifidWrite   = 1'b1;
    w_ifidFlush   = 1'b0;
    w_idexBubble  = 1'b0;
    w_freeze      = 1'b0;
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    if (!i_reset) begin
      case (r_state)
        S_RUN: begin
          if (w_memWait) begin
            w_pcWrite     = 1'b0;
            w_ifidWrite   = 1'b0;
            w_freeze      = 1'b1;
            w_nextState   = S_MEMWAIT;
            w_nextWaitCnt = WCNT_W'(1);
          end else if (i_EX_BranchTaken) begin
            w_ifidFlush  = 1'b1;
            w_idexBubble = 1'b1;
          end else if (w_loadUse) begin
            w_pcWrite    = 1'b0;
            w_ifidWrite  = 1'b0;
            w_idexBubble = 1'b1;
          end
        end
        S_MEMWAIT: begin
          w_pcWrite   = 1'b0;
          w_ifidWrite = 1'b0;
          w_freeze    = 1'b1;
          if (i_MemReady) begin
            w_nextState   = S_RUN;
            w_nextWaitCnt = '0;
          end else if (r_waitCnt == LIMIT_VAL) begin
            w_nextState = S_ERROR;
          end else begin
            w_nextWaitCnt = r_waitCnt + 1'b1;
          end
        end
        default: begin
          w_pcWrite   = 1'b0;
          w_ifidWrite = 1'b0;
          w_freeze    = 1'b1;
          w_nextState = S_ERROR;
        end
      endcase
    end
  end

  // Branch flushes keep the PC moving, so they are not counted as stalls.
  assign w_stallCycle = ~w_pcWrite | w_freeze;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_RUN;
      r_waitCnt    <= '0;
      r_memError   <= 1'b0;
      r_stallCount <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (w_nextState == S_ERROR) begin
        r_memError <= 1'b1;
      end
      if (w_stallCycle && (r_stallCount != '1)) begin
        r_stallCount <= r_stallCount + 1'b1;
      end
    end
  end

  assign o_PC_Write    = w_pcWrite;
  assign o_IFID_Write  = w_ifidWrite;
  assign o_IFID_Flush  = w_ifidFlush;
  assign o_IDEX_Bubble = w_idexBubble;
  assign o_Freeze      = w_freeze;
  assign o_MemError    = r_memError;
  assign o_StallCount  = r_stallCount;

endmodule
